// File: rtl/bf16_macc_operand_feeder_if.sv
// bf16_macc_operand_feeder_if: operand stream, MACC issue/result and result stream bundle
interface bf16_macc_operand_feeder_if #(parameter int N_PAIRS = 9);
   logic                   s_valid;
   logic                   s_ready;
   logic [15:0]            s_a;
   logic [15:0]            s_b;
   logic                   s_last;
   logic [32*N_PAIRS-1:0]  macc_operands;
   logic [15:0]            macc_result;
   logic                   m_valid;
   logic                   m_ready;
   logic [15:0]            m_data;
   logic                   busy;
   // feeder side
   modport master (
      input  s_valid, s_a, s_b, s_last, macc_result, m_ready,
      output s_ready, macc_operands, m_valid, m_data, busy
   );
   // environment side: operand source, MACC and result consumer
   modport slave (
      output s_valid, s_a, s_b, s_last, macc_result, m_ready,
      input  s_ready, macc_operands, m_valid, m_data, busy
   );
endinterface

// File: rtl/bf16_macc_operand_feeder.sv
// bf16_macc_operand_feeder: assembles bf16 operand pairs into MACC vectors, credit-gates issue,
// tags results by MACC latency and buffers them in a result FIFO. Optional FEEDER_FTZ_EN flushes
// subnormal operands to signed zero at acceptance.
module bf16_macc_operand_feeder #(
   parameter int N_PAIRS   = 9,
   parameter int MACC_LAT  = 14,
   parameter int RES_DEPTH = 4
) (
   input logic                          clk,
   input logic                          reset,
   bf16_macc_operand_feeder_if.master   bus
);
   localparam int IW = $clog2(N_PAIRS);
   localparam int CW = $clog2(RES_DEPTH) + 1;
   localparam int PW = $clog2(RES_DEPTH);

   typedef enum logic [1:0] {COLLECT, WAIT_CREDIT, ISSUE} state_t;

   state_t                 state_q;
   logic                   s_ready_q;
   logic [IW-1:0]          idx_q;
   logic [32*N_PAIRS-1:0]  vec_q;
   logic [MACC_LAT-1:0]    tag_q;
   logic [CW-1:0]          infl_q;
   logic [CW-1:0]          cnt_q;
   logic [PW-1:0]          wr_q;
   logic [PW-1:0]          rd_q;
   logic [15:0]            mem_q [RES_DEPTH];
   logic                   accept, last, issue, push, pop, m_valid, credit;
   logic [CW:0]            used;

   function automatic logic [15:0] ftz(input logic [15:0] x);
`ifdef FEEDER_FTZ_EN
      return (x[14:7] == 8'h0 && x[6:0] != 7'h0) ? {x[15], 15'h0} : x;
`else
      return x;
`endif
   endfunction

   assign accept  = bus.s_valid & s_ready_q;
   assign last    = accept & (bus.s_last | idx_q == IW'(N_PAIRS - 1));
   assign issue   = state_q == ISSUE;
   assign push    = tag_q[MACC_LAT-1];
   assign m_valid = cnt_q != '0;
   assign pop     = m_valid & bus.m_ready;
   assign used    = {1'b0, infl_q} + {1'b0, cnt_q};
   assign credit  = used < (CW+1)'(RES_DEPTH) + (CW+1)'(pop);

   assign bus.s_ready       = s_ready_q;
   assign bus.macc_operands = issue ? vec_q : '0;
   assign bus.m_valid       = m_valid;
   assign bus.m_data        = m_valid ? mem_q[rd_q] : '0;
   assign bus.busy          = state_q != COLLECT || idx_q != '0 || infl_q != '0 || cnt_q != '0;

   // Collection/issue sequencer; s_ready is a registered output of the FSM
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= COLLECT;
         s_ready_q <= 1'b0;
         idx_q     <= '0;
         vec_q     <= '0;
      end else begin
         case (state_q)
            COLLECT: begin
               s_ready_q <= !last;
               if (accept) begin
                  vec_q[32*idx_q +: 32] <= {ftz(bus.s_b), ftz(bus.s_a)};
                  idx_q                 <= idx_q + IW'(1);
               end
               if (last) state_q <= credit ? ISSUE : WAIT_CREDIT;
            end
            WAIT_CREDIT: if (credit) state_q <= ISSUE;
            default: begin
               state_q   <= COLLECT;
               s_ready_q <= 1'b1;
               idx_q     <= '0;
               vec_q     <= '0;
            end
         endcase
      end
   end

   // Latency tag pipeline mirrors the MACC; the exiting tag marks a valid macc_result
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_q  <= '0;
         infl_q <= '0;
      end else begin
         tag_q  <= {tag_q[MACC_LAT-2:0], issue};
         infl_q <= infl_q + CW'(issue) - CW'(push);
      end
   end

   // Result FIFO control; never full on push because issue is credit-gated
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + PW'(1);
         if (pop) rd_q <= rd_q + PW'(1);
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
   end

   // Result storage; contents are only observable while the count is non-zero
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= bus.macc_result;
   end
endmodule
